edge_rasterizer: RTL and testbench
==================================

Name: edge_rasterizer

Overview:
Parametrised successor to the fixed-size wireframe rasterizer. It takes one 2D screen-space triangle per handshake, walks its three edges P->Q, Q->R, R->P with Bresenham stepping, and emits one colored pixel write per cycle. Additions over the previous generation:
- configurable frame size, coordinate width and color depth
- point mode
- write backpressure
- off-screen clipping
It sits between the triangle source (vertex/projection stage) and the frame-buffer write port.

Parameters:
WIDTH, 640, frame width in pixels
HEIGHT, 480, frame height in pixels
COORD_W, 10, unsigned vertex coordinate width; must satisfy 2^COORD_W >= max(WIDTH,HEIGHT)
COLOR_W, 24, pixel data width
ADDR_W, $clog2(WIDTH*HEIGHT), frame-buffer address width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
tri_ready  in  1  triangle and color valid at inputs
itriangle  in  6*COORD_W  {Px,Py,Qx,Qy,Rx,Ry}, Px in MSBs
icolor  in  COLOR_W  edge color
mode  in  1  0 = wireframe, 1 = points only; sampled with the triangle
tri_read  out  1  one-cycle pulse: triangle consumed
write_en  out  1  pixel write valid
addr  out  ADDR_W  y*WIDTH + x
wf_data  out  COLOR_W  pixel color
wr_ready  in  1  frame buffer accepts the write this cycle
busy  out  1  high from triangle acceptance until done
done  out  1  one-cycle pulse after the last pixel is accepted

Behaviour:
- Reset: rst is asynchronous and active-high. State goes to IDLE. tri_read, write_en, busy and done are 0; addr and wf_data are 0. Reset mid-triangle abandons it, with no done pulse.
- State machine: IDLE -> SETUP -> DRAW -> (NEXT_EDGE -> DRAW)x2 -> FINISH -> IDLE.
- IDLE:
  - When tri_ready=1 on an edge, latch itriangle, icolor and mode; tri_read=1 and busy=1 in the next cycle (SETUP). tri_read is never high twice per triangle.
  - tri_ready is ignored outside IDLE.
- SETUP / NEXT_EDGE (1 cycle each):
  - Load edge endpoints (x0,y0)->(x1,y1).
  - dx = |x1-x0|; dy = -|y1-y0|; sx, sy = ±1; err = dx+dy.
  - All stepping arithmetic is signed, COORD_W+2 bits.
- DRAW: one candidate pixel per cycle.
  - Stepping rule: e2 = 2*err; if e2 >= dy, then err += dy and x += sx; if e2 <= dx, then err += dx and y += sy.
  - The endpoint is included, so the edge produces max(dx,-dy)+1 pixels.
  - Shared vertices are written once per edge that touches them (intentional).
- Latency: the first write_en is 2 cycles after tri_ready is sampled.
- Backpressure:
  - If write_en=1 and wr_ready=0, hold write_en, addr, wf_data and the stepper state.
  - A pixel is accepted on write_en & wr_ready; the stepper then advances.
- Clipping: a pixel with x>=WIDTH or y>=HEIGHT gets write_en=0. The stepper still advances in that cycle; wr_ready is ignored for it.
- Point mode: emit P, Q, R as single pixels, one per accepted cycle, with the same clipping and backpressure. No NEXT_EDGE setup cycles are inserted.
- FINISH: done=1 for one cycle, busy drops in the same cycle, and the next cycle is IDLE. A new triangle is accepted on the cycle after done at the earliest.
- Degenerate edges (x0=x1, y0=y1) produce exactly one pixel.

Decomposition:
- defines_package gets:
  - vertex field index constants (PX..RY slice offsets)
  - mode encodings (MODE_WIRE, MODE_POINT)
  - state enum RastState
- Sub-module bresenham_stepper:
  - Ports: clk, rst, load, advance, x0, y0, x1, y1 in; x, y, last out.
  - Parametrised by COORD_W.
  - The top owns the FSM, clipping, addressing and handshakes.

Test Plan:
1. WIDTH=HEIGHT=8, P=(1,1), Q=(4,1), R=(1,4), wr_ready=1 -> 12 writes, addr sequence 9,10,11,12, 12,19,26,33, 33,25,17,9; done one cycle after the last write; tri_read pulses once.
2. All vertices (5,5) -> 3 writes to addr 45, with 2 NEXT_EDGE gaps, then done.
3. Case 1 with wr_ready low for 3 cycles at the 2nd pixel -> addr=10 held stable for the whole stall; total accepted writes still 12; done delayed 3 cycles.
4. COORD_W=4, WIDTH=HEIGHT=8, P=(6,0), Q=(9,0), R=(6,0) -> writes only at 6,7, 7,6, 6; 9 DRAW cycles total; done asserted.
5. mode=1, P=(0,0), Q=(7,7), R=(9,1) with COORD_W=4 -> writes addr 0 and 63 only (R clipped); done.
6. Assert rst mid-DRAW of case 1 -> all outputs 0 immediately, no done; a fresh triangle afterwards completes correctly.

Source files
------------

// File: rtl/edge_rasterizer_pkg.sv
// Shared definitions for the edge rasterizer: vertex field layout, draw modes
// and the controller state encoding.
package edge_rasterizer_pkg;

  // Field index inside itriangle; field i occupies bits [i*COORD_W +: COORD_W].
  localparam int PX = 5;
  localparam int PY = 4;
  localparam int QX = 3;
  localparam int QY = 2;
  localparam int RX = 1;
  localparam int RY = 0;

  localparam logic MODE_WIRE  = 1'b0;
  localparam logic MODE_POINT = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETUP     = 3'd1,
    ST_DRAW      = 3'd2,
    ST_NEXT_EDGE = 3'd3,
    ST_FINISH    = 3'd4
  } rast_state_t;

  // Edge e runs from vertex e to vertex edge_end(e): P->Q, Q->R, R->P.
  function automatic logic [1:0] edge_end(input logic [1:0] e);
    return (e == 2'd2) ? 2'd0 : e + 2'd1;
  endfunction

endpackage

// File: rtl/edge_rasterizer_stepper.sv
// Bresenham line stepper: load an edge, then each advance moves one pixel
// toward the endpoint; last flags that the current pixel is the endpoint.
module edge_rasterizer_stepper #(
  parameter int COORD_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               advance,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last
);

  localparam int SW = COORD_W + 2;

  logic [COORD_W-1:0]  x_q, x_d, y_q, y_d, xe_q, xe_d, ye_q, ye_d;
  logic signed [SW-1:0] err_q, err_d, dx_q, dx_d, dy_q, dy_d;
  logic                sxn_q, sxn_d, syn_q, syn_d;
  logic [COORD_W-1:0]  adx_s, ady_s;
  logic signed [SW-1:0] err_s;
  // e2 and the compared terms get one extra bit so 2*err never wraps.
  logic signed [SW:0]  e2_s, dxw_s, dyw_s;

  // Next-state stepping arithmetic.
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    xe_d  = xe_q;
    ye_d  = ye_q;
    err_d = err_q;
    dx_d  = dx_q;
    dy_d  = dy_q;
    sxn_d = sxn_q;
    syn_d = syn_q;
    err_s = err_q;
    adx_s = (x1 < x0) ? (x0 - x1) : (x1 - x0);
    ady_s = (y1 < y0) ? (y0 - y1) : (y1 - y0);
    e2_s  = {err_q, 1'b0};
    dxw_s = {dx_q[SW-1], dx_q};
    dyw_s = {dy_q[SW-1], dy_q};
    if (load) begin
      x_d   = x0;
      y_d   = y0;
      xe_d  = x1;
      ye_d  = y1;
      sxn_d = (x1 < x0);
      syn_d = (y1 < y0);
      dx_d  = $signed({2'b00, adx_s});
      dy_d  = -$signed({2'b00, ady_s});
      err_d = $signed({2'b00, adx_s}) - $signed({2'b00, ady_s});
    end else if (advance) begin
      if (e2_s >= dyw_s) begin
        err_s = err_s + dy_q;
        x_d   = sxn_q ? (x_q - COORD_W'(1)) : (x_q + COORD_W'(1));
      end else begin
        x_d   = x_q;
      end
      if (e2_s <= dxw_s) begin
        err_s = err_s + dx_q;
        y_d   = syn_q ? (y_q - COORD_W'(1)) : (y_q + COORD_W'(1));
      end else begin
        y_d   = y_q;
      end
      err_d = err_s;
    end else begin
      err_d = err_q;
    end
  end

  // Stepper state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q   <= '0;
      y_q   <= '0;
      xe_q  <= '0;
      ye_q  <= '0;
      err_q <= '0;
      dx_q  <= '0;
      dy_q  <= '0;
      sxn_q <= 1'b0;
      syn_q <= 1'b0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      xe_q  <= xe_d;
      ye_q  <= ye_d;
      err_q <= err_d;
      dx_q  <= dx_d;
      dy_q  <= dy_d;
      sxn_q <= sxn_d;
      syn_q <= syn_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = (x_q == xe_q) && (y_q == ye_q);

endmodule

// File: rtl/edge_rasterizer.sv
// Triangle wireframe/point rasterizer: accepts one triangle per handshake and
// emits clipped, backpressured frame-buffer writes along its three edges.
module edge_rasterizer
  import edge_rasterizer_pkg::*;
#(
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int COORD_W = 10,
  parameter int COLOR_W = 24,
  parameter int ADDR_W  = $clog2(WIDTH * HEIGHT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tri_ready,
  input  logic [6*COORD_W-1:0] itriangle,
  input  logic [COLOR_W-1:0]   icolor,
  input  logic                 mode,
  output logic                 tri_read,
  output logic                 write_en,
  output logic [ADDR_W-1:0]    addr,
  output logic [COLOR_W-1:0]   wf_data,
  input  logic                 wr_ready,
  output logic                 busy,
  output logic                 done
);

  localparam logic [COORD_W:0]  W_LIM = (COORD_W+1)'(WIDTH);
  localparam logic [COORD_W:0]  H_LIM = (COORD_W+1)'(HEIGHT);
  localparam logic [ADDR_W-1:0] W_A   = ADDR_W'(WIDTH);

  rast_state_t          state_q, state_d;
  logic [1:0]           edge_q, edge_d;
  logic                 mode_q, mode_d;
  logic [6*COORD_W-1:0] tri_q, tri_d;
  logic [COLOR_W-1:0]   color_q, color_d;
  logic                 tri_read_q, tri_read_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 load_s, adv_s, last_s, vis_s, accept_s;
  logic [COORD_W-1:0]   x_s, y_s, x0_s, y0_s, x1_s, y1_s;

  function automatic logic [2*COORD_W-1:0] vertex(input logic [6*COORD_W-1:0] t,
                                                  input logic [1:0] i);
    case (i)
      2'd0:    return {t[PX*COORD_W +: COORD_W], t[PY*COORD_W +: COORD_W]};
      2'd1:    return {t[QX*COORD_W +: COORD_W], t[QY*COORD_W +: COORD_W]};
      default: return {t[RX*COORD_W +: COORD_W], t[RY*COORD_W +: COORD_W]};
    endcase
  endfunction

  // Clipped pixels are skipped without waiting for the frame buffer.
  assign vis_s    = ({1'b0, x_s} < W_LIM) && ({1'b0, y_s} < H_LIM);
  assign accept_s = !vis_s || wr_ready;

  // Controller next-state and stepper control.
  always_comb begin
    state_d    = state_q;
    edge_d     = edge_q;
    mode_d     = mode_q;
    tri_d      = tri_q;
    color_d    = color_q;
    tri_read_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    load_s     = 1'b0;
    adv_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tri_ready) begin
          tri_d      = itriangle;
          color_d    = icolor;
          mode_d     = mode;
          edge_d     = 2'd0;
          tri_read_d = 1'b1;
          busy_d     = 1'b1;
          state_d    = ST_SETUP;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_SETUP, ST_NEXT_EDGE: begin
        load_s  = 1'b1;
        state_d = ST_DRAW;
      end
      ST_DRAW: begin
        if (accept_s) begin
          if (last_s) begin
            if (edge_q == 2'd2) begin
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = ST_FINISH;
            end else begin
              edge_d = edge_q + 2'd1;
              // Point mode reloads in place, so consecutive vertices have no gap.
              if (mode_q == MODE_POINT) begin
                load_s  = 1'b1;
                state_d = ST_DRAW;
              end else begin
                state_d = ST_NEXT_EDGE;
              end
            end
          end else begin
            adv_s = 1'b1;
          end
        end else begin
          state_d = ST_DRAW;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Endpoint selection for the edge (or point) being loaded.
  always_comb begin
    {x0_s, y0_s} = vertex(tri_q, edge_d);
    if (mode_q == MODE_POINT) begin
      {x1_s, y1_s} = {x0_s, y0_s};
    end else begin
      {x1_s, y1_s} = vertex(tri_q, edge_end(edge_d));
    end
  end

  // Controller registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      edge_q     <= 2'd0;
      mode_q     <= MODE_WIRE;
      tri_q      <= '0;
      color_q    <= '0;
      tri_read_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_q     <= edge_d;
      mode_q     <= mode_d;
      tri_q      <= tri_d;
      color_q    <= color_d;
      tri_read_q <= tri_read_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  edge_rasterizer_stepper #(.COORD_W(COORD_W)) u_stepper (
    .clk     (clk),
    .rst     (rst),
    .load    (load_s),
    .advance (adv_s),
    .x0      (x0_s),
    .y0      (y0_s),
    .x1      (x1_s),
    .y1      (y1_s),
    .x       (x_s),
    .y       (y_s),
    .last    (last_s)
  );

  assign tri_read = tri_read_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign write_en = (state_q == ST_DRAW) && vis_s;
  assign addr     = ADDR_W'(y_s) * W_A + ADDR_W'(x_s);
  assign wf_data  = color_q;

endmodule

// File: tb/tb_edge_rasterizer.sv
// Self-checking bench for edge_rasterizer: directed plan cases plus random
// triangles, compared against a plain integer Bresenham reference model.
module tb_edge_rasterizer;

  localparam int W    = 8;
  localparam int H    = 8;
  localparam int CW   = 4;
  localparam int COLW = 24;
  localparam int AW   = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              tri_ready = 1'b0;
  logic [6*CW-1:0]   itriangle = '0;
  logic [COLW-1:0]   icolor = '0;
  logic              mode = 1'b0;
  logic              wr_ready = 1'b1;
  logic              tri_read, write_en, busy, done;
  logic [AW-1:0]     addr;
  logic [COLW-1:0]   wf_data;

  edge_rasterizer #(.WIDTH(W), .HEIGHT(H), .COORD_W(CW), .COLOR_W(COLW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .tri_ready(tri_ready), .itriangle(itriangle), .icolor(icolor),
    .mode(mode), .tri_read(tri_read), .write_en(write_en), .addr(addr), .wf_data(wf_data),
    .wr_ready(wr_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Observation: accepted writes, pulses and stall-hold snapshots.
  int          cyc = 0;
  int          got_addr[$];
  int          got_data[$];
  logic [31:0] hold_got[$];
  logic [31:0] hold_exp[$];
  int          tr_cnt = 0, done_cnt = 0, stalls = 0, done_cyc = 0;
  logic        prev_stall = 1'b0;
  logic [29:0] prev_word = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        hold_got.push_back({1'b0, write_en, wf_data, addr});
        hold_exp.push_back({1'b0, 1'b1, prev_word});
      end
      if (write_en && wr_ready) begin
        got_addr.push_back(int'(addr));
        got_data.push_back(int'(wf_data));
      end
      if (write_en && !wr_ready) stalls <= stalls + 1;
      prev_stall <= write_en && !wr_ready;
      prev_word  <= {wf_data, addr};
      if (tri_read) tr_cnt <= tr_cnt + 1;
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
    end
  end

  // Frame-buffer readiness: always, random, or a 3-cycle stall on the 2nd pixel.
  int rdy_mode = 0;
  int acc_base = 0;
  int st_cnt   = 0;
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 2) begin
      if (write_en && (got_addr.size() - acc_base == 1) && st_cnt < 3) begin
        wr_ready = 1'b0;
        st_cnt   = st_cnt + 1;
      end else begin
        wr_ready = 1'b1;
      end
    end else begin
      st_cnt   = 0;
      wr_ready = (rdy_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Reference model: visible addresses in emission order and total candidate pixels.
  int vx[3];
  int vy[3];
  int exp_addr[$];
  int exp_pix;

  function automatic void emit(int x, int y);
    exp_pix++;
    if (x < W && y < H) exp_addr.push_back(y * W + x);
  endfunction

  function automatic void build(bit pm);
    exp_addr.delete();
    exp_pix = 0;
    for (int e = 0; e < 3; e++) begin
      if (pm) begin
        emit(vx[e], vy[e]);
      end else begin
        int x, y, x1, y1, dx, dy, sx, sy, err, e2;
        x  = vx[e];  y  = vy[e];
        x1 = vx[(e + 1) % 3];  y1 = vy[(e + 1) % 3];
        dx = (x1 > x) ? x1 - x : x - x1;
        dy = (y1 > y) ? y - y1 : y1 - y;
        sx = (x < x1) ? 1 : -1;
        sy = (y < y1) ? 1 : -1;
        err = dx + dy;
        for (int k = 0; k < 64; k++) begin
          emit(x, y);
          if (x == x1 && y == y1) break;
          e2 = 2 * err;
          if (e2 >= dy) begin err += dy; x += sx; end
          if (e2 <= dx) begin err += dx; y += sy; end
        end
      end
    end
  endfunction

  // Runs one triangle from IDLE (called at posedge+1) and checks everything it produced.
  task automatic run_tri(input int px, py, qx, qy, rx, ry, input logic [COLW-1:0] col,
                         input bit pm, input int rmode, input string tag);
    int a, b_addr, b_tr, b_done, b_stall, b_hold, ngot, nexp;
    vx[0] = px; vx[1] = qx; vx[2] = rx;
    vy[0] = py; vy[1] = qy; vy[2] = ry;
    build(pm);
    rdy_mode = rmode;
    acc_base = got_addr.size();
    b_addr = got_addr.size(); b_tr = tr_cnt; b_done = done_cnt;
    b_stall = stalls; b_hold = hold_got.size();
    itriangle = {CW'(px), CW'(py), CW'(qx), CW'(qy), CW'(rx), CW'(ry)};
    icolor = col;
    mode = pm;
    tri_ready = 1'b1;
    @(posedge clk); #1;
    a = cyc;
    tri_ready = 1'b0;
    itriangle = CW*6'($urandom);
    icolor = COLW'($urandom);
    mode = 1'($urandom_range(0, 1));
    check_eq({tag, "_tri_read"}, 32'(tri_read), 32'd1);
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    check_eq({tag, "_setup_we"}, 32'(write_en), 32'd0);
    @(posedge clk); #1;
    check_eq({tag, "_first_we"}, 32'(write_en), 32'(px < W && py < H));
    for (int i = 0; i < 3000; i++) begin
      if (done_cnt != b_done) break;
      @(negedge clk); #1;
    end
    check_eq({tag, "_done_seen"}, 32'(done_cnt != b_done), 32'd1);
    check_eq({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check_eq({tag, "_done_cycle"}, 32'(done_cyc - a),
             32'(1 + exp_pix + (stalls - b_stall) + (pm ? 0 : 2)));
    repeat (3) @(negedge clk);
    #1;
    check_eq({tag, "_done_pulses"}, 32'(done_cnt - b_done), 32'd1);
    check_eq({tag, "_tri_read_pulses"}, 32'(tr_cnt - b_tr), 32'd1);
    ngot = got_addr.size() - b_addr;
    nexp = exp_addr.size();
    check_eq({tag, "_nwrites"}, 32'(ngot), 32'(nexp));
    for (int k = 0; k < ngot && k < nexp; k++) begin
      check_eq({tag, "_addr"}, 32'(got_addr[b_addr + k]), 32'(exp_addr[k]));
      check_eq({tag, "_data"}, 32'(got_data[b_addr + k]), 32'(col));
    end
    for (int k = b_hold; k < hold_got.size(); k++)
      check_eq({tag, "_stall_hold"}, hold_got[k], hold_exp[k]);
    if (rmode == 2) check_eq({tag, "_stall_cycles"}, 32'(stalls - b_stall), 32'd3);
    rdy_mode = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    int b_done;
    #2;
    check_eq("rst_tri_read", 32'(tri_read), 32'd0);
    check_eq("rst_write_en", 32'(write_en), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_addr", 32'(addr), 32'd0);
    check_eq("rst_wf_data", 32'(wf_data), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    run_tri(1, 1, 4, 1, 1, 4, 24'hA1B2C3, 1'b0, 0, "t1");
    run_tri(5, 5, 5, 5, 5, 5, 24'h00FF00, 1'b0, 0, "t2");
    run_tri(1, 1, 4, 1, 1, 4, 24'h123456, 1'b0, 2, "t3");
    run_tri(6, 0, 9, 0, 6, 0, 24'h0000FF, 1'b0, 0, "t4");
    run_tri(0, 0, 7, 7, 9, 1, 24'hFEDCBA, 1'b1, 0, "t5");

    // Reset in the middle of drawing abandons the triangle without done.
    b_done = done_cnt;
    itriangle = {CW'(1), CW'(1), CW'(4), CW'(1), CW'(1), CW'(4)};
    icolor = 24'h777777;
    mode = 1'b0;
    tri_ready = 1'b1;
    @(posedge clk); #1;
    tri_ready = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_eq("t6_rst_tri_read", 32'(tri_read), 32'd0);
    check_eq("t6_rst_write_en", 32'(write_en), 32'd0);
    check_eq("t6_rst_busy", 32'(busy), 32'd0);
    check_eq("t6_rst_done", 32'(done), 32'd0);
    check_eq("t6_rst_addr", 32'(addr), 32'd0);
    check_eq("t6_rst_wf_data", 32'(wf_data), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_eq("t6_no_done", 32'(done_cnt - b_done), 32'd0);
    run_tri(1, 1, 4, 1, 1, 4, 24'hA1B2C3, 1'b0, 0, "t6b");

    for (int n = 0; n < 30; n++) begin
      run_tri($urandom_range(0, 11), $urandom_range(0, 11), $urandom_range(0, 11),
              $urandom_range(0, 11), $urandom_range(0, 11), $urandom_range(0, 11),
              COLW'($urandom), ($urandom_range(0, 3) == 0), 1, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
